itoa: RTL and testbench



---
 rtl/itoa_pkg.sv | 15 +
 rtl/itoa_if.sv | 17 +
 rtl/itoa_bin2bcd.sv | 34 +++
 rtl/itoa.sv | 132 +++++++++++++
 tb/tb_itoa.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/itoa_pkg.sv
// Shared Forth-core definitions: itoa state encoding, ASCII constants, digit-to-ASCII.
package forthsuper_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, CNV = 2'd1, LZS = 2'd2, EMT = 2'd3} itoa_sts;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SP    = 8'h20;

    function automatic logic [7:0] d2a(input logic [3:0] d);
        return (d < 4'd10) ? (ASC_0 + {4'h0, d}) : (ASC_A + {4'h0, d} - 8'd10);
    endfunction

endpackage

// File: rtl/itoa_if.sv
// Request/emit bundle between the output path and the itoa converter.
interface itoa_if #(parameter int DSZ = 32);
    import forthsuper_pkg::*;

    logic           en;
    logic           hex;
    logic [DSZ-1:0] vi;
    logic           bsy;
    logic           we;
    logic           af;
    logic [7:0]     ch;
    logic [3:0]     len;
    itoa_sts        st;

    modport master (output en, hex, vi, input bsy, we, af, ch, len, st);
    modport slave  (input en, hex, vi, output bsy, we, af, ch, len, st);
endinterface

// File: rtl/itoa_bin2bcd.sv
// Double-dabble datapath; in hex mode the digit register is loaded with raw nibbles.
module bin2bcd #(
    parameter int DSZ  = 32,
    parameter int NDIG = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              hex,
    input  logic              step,
    input  logic [DSZ-1:0]    val,
    output logic [NDIG*4-1:0] bcd
);
    logic [DSZ-1:0]    sh;
    logic [NDIG*4-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIG; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd <= '0;
            sh  <= '0;
        end else if (load) begin
            bcd <= hex ? (NDIG*4)'(val) : '0;
            sh  <= hex ? '0 : val;
        end else if (step) begin
            {bcd, sh} <= {adj[NDIG*4-2:0], sh, 1'b0};
        end
    end
endmodule

// File: rtl/itoa.sv
// Integer-to-ASCII converter: signed decimal or unsigned hex, one character per cycle.
// Optional feature macro: ITOA_SPACE_EN appends a trailing space after the digits.
module itoa
    import forthsuper_pkg::*;
#(
    parameter int DSZ  = 32,
    parameter int NDIG = 10
) (
    input  logic  clk,
    input  logic  rst,
    itoa_if.slave bus
);
    localparam int CW = $clog2(DSZ) + 1;
    localparam int IW = $clog2(NDIG);

    itoa_sts           st, st_n;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx, msd;
    logic              sgn, bsy, we, we_n, last, start, neg_in;
    logic [7:0]        ch, ch_n;
    logic [3:0]        len;
    logic [3:0]        cur;
    logic [DSZ-1:0]    mag;
    logic [NDIG*4-1:0] bcd;
`ifdef ITOA_SPACE_EN
    logic              spc;
`endif

    assign start  = (st == IDLE) && bus.en;
    assign neg_in = ~bus.hex & bus.vi[DSZ-1];
    // Unsigned negate, so the most-negative value yields 2^(DSZ-1)
    assign mag    = neg_in ? (~bus.vi + DSZ'(1)) : bus.vi;

    bin2bcd #(.DSZ(DSZ), .NDIG(NDIG)) u_b2b (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .hex  (bus.hex),
        .step (st == CNV),
        .val  (mag),
        .bcd  (bcd)
    );

    // Hex leaves the digits above DSZ/4 zero, so one scan covers both modes
    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIG; i++)
            if (bcd[4*i +: 4] != 4'd0) msd = IW'(i);
    end

    assign cur = bcd[4*idx +: 4];

    always_comb begin
        st_n = st;
        we_n = 1'b0;
        ch_n = ch;
        last = 1'b0;
        case (st)
            IDLE: if (bus.en) st_n = bus.hex ? LZS : CNV;
            CNV:  if (cnt == CW'(DSZ - 1)) st_n = LZS;
            LZS:  st_n = EMT;
            EMT: begin
                we_n = 1'b1;
                if (sgn) ch_n = ASC_MINUS;
`ifdef ITOA_SPACE_EN
                else if (spc) begin
                    ch_n = ASC_SP;
                    last = 1'b1;
                end else ch_n = d2a(cur);
`else
                else begin
                    ch_n = d2a(cur);
                    last = (idx == '0);
                end
`endif
                if (last) st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
            idx <= '0;
            sgn <= 1'b0;
            bsy <= 1'b0;
            we  <= 1'b0;
            ch  <= '0;
            len <= '0;
`ifdef ITOA_SPACE_EN
            spc <= 1'b0;
`endif
        end else begin
            st <= st_n;
            we <= we_n;
            ch <= ch_n;
            case (st)
                IDLE: begin
                    bsy <= bus.en;
                    if (bus.en) begin
                        sgn <= neg_in;
                        cnt <= '0;
                        len <= '0;
`ifdef ITOA_SPACE_EN
                        spc <= 1'b0;
`endif
                    end
                end
                CNV: cnt <= cnt + 1'b1;
                LZS: idx <= msd;
                EMT: begin
                    len <= len + 1'b1;
                    if (sgn) sgn <= 1'b0;
                    else if (idx != '0) idx <= idx - 1'b1;
`ifdef ITOA_SPACE_EN
                    else spc <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.bsy = bsy;
    assign bus.we  = we;
    assign bus.af  = we;
    assign bus.ch  = ch;
    assign bus.len = len;
    assign bus.st  = st;
endmodule

// File: tb/tb_itoa.sv
// Directed bench for itoa: decimal/hex strings, latency, reset abort, busy-ignore, back-to-back.
module tb_itoa;
    import forthsuper_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    itoa_if #(.DSZ(32)) bus ();
    itoa #(.DSZ(32), .NDIG(10)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ITOA_SPACE_EN
    localparam int SP = 1;
    localparam string SFX = " ";
`else
    localparam int SP = 0;
    localparam string SFX = "";
`endif

    // results of the last run()
    string gs;
    int    ncap, first_we, bsy_start, bsy_end, timeout, afbad, len_end;

    task automatic run(input logic [31:0] v, input logic h, input int pulse_at);
        int c = 0;
        int done = 0;
        @(negedge clk);
        bus.en = 1'b1; bus.hex = h; bus.vi = v;
        @(posedge clk); #1;
        bus.en = 1'b0;
        bsy_start = bus.bsy;
        gs = ""; ncap = 0; first_we = -1; afbad = 0; bsy_end = -1; len_end = -1;
        while (!done && c < 200) begin
            @(posedge clk); #1;
            c++;
            bus.en = 1'b0;
            if (c == pulse_at) begin
                bus.en = 1'b1; bus.hex = 1'b1; bus.vi = 32'h0000_0777;
            end
            if (bus.af !== bus.we) afbad = 1;
            if (bus.we === 1'b1) begin
                if (first_we < 0) first_we = c;
                gs = $sformatf("%s%c", gs, bus.ch);
                ncap++;
            end else if (ncap > 0) begin
                done = 1;
                bsy_end = bus.bsy;
                len_end = bus.len;
            end
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.st !== IDLE) begin failures++; $display("FAIL reset_st got=%0d want=0", bus.st); end
        checks++; if (bus.bsy !== 1'b0) begin failures++; $display("FAIL reset_bsy got=%b want=0", bus.bsy); end
        checks++; if (bus.we !== 1'b0 || bus.af !== 1'b0) begin failures++; $display("FAIL reset_we got=%b%b want=00", bus.we, bus.af); end
        checks++; if (bus.ch !== 8'h00) begin failures++; $display("FAIL reset_ch got=%h want=00", bus.ch); end
        checks++; if (bus.len !== 4'd0) begin failures++; $display("FAIL reset_len got=%0d want=0", bus.len); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_dec_12345();
        string e = {"12345", SFX};
        run(32'd12345, 1'b0, -1);
        checks++; if (timeout != 0) begin failures++; $display("FAIL dec12345_timeout got=%0d want=0", timeout); end
        checks++; if (gs != e) begin failures++; $display("FAIL dec12345_str got='%s' want='%s'", gs, e); end
        checks++; if (first_we != 34) begin failures++; $display("FAIL dec12345_lat got=%0d want=34", first_we); end
        checks++; if (len_end != 5 + SP) begin failures++; $display("FAIL dec12345_len got=%0d want=%0d", len_end, 5 + SP); end
        checks++; if (bsy_start != 1 || bsy_end != 0) begin failures++; $display("FAIL dec12345_bsy got=%0d/%0d want=1/0", bsy_start, bsy_end); end
        checks++; if (afbad != 0) begin failures++; $display("FAIL dec12345_af got=%0d want=0", afbad); end
    endtask

    task automatic test_dec_signed();
        string e1 = {"-1", SFX};
        string e2 = {"-2147483648", SFX};
        run(32'hFFFF_FFFF, 1'b0, -1);
        checks++; if (gs != e1) begin failures++; $display("FAIL dec_m1_str got='%s' want='%s'", gs, e1); end
        checks++; if (len_end != 2 + SP) begin failures++; $display("FAIL dec_m1_len got=%0d want=%0d", len_end, 2 + SP); end
        run(32'h8000_0000, 1'b0, -1);
        checks++; if (gs != e2) begin failures++; $display("FAIL dec_min_str got='%s' want='%s'", gs, e2); end
        checks++; if (len_end != 11 + SP) begin failures++; $display("FAIL dec_min_len got=%0d want=%0d", len_end, 11 + SP); end
    endtask

    task automatic test_zero();
        string e = {"0", SFX};
        run(32'd0, 1'b0, -1);
        checks++; if (gs != e) begin failures++; $display("FAIL dec0_str got='%s' want='%s'", gs, e); end
        checks++; if (len_end != 1 + SP) begin failures++; $display("FAIL dec0_len got=%0d want=%0d", len_end, 1 + SP); end
        run(32'd0, 1'b1, -1);
        checks++; if (gs != e) begin failures++; $display("FAIL hex0_str got='%s' want='%s'", gs, e); end
        checks++; if (first_we != 2) begin failures++; $display("FAIL hex0_lat got=%0d want=2", first_we); end
    endtask

    task automatic test_hex();
        string e1 = {"DEAD42", SFX};
        string e2 = {"FFFFFFFF", SFX};
        run(32'h00DE_AD42, 1'b1, -1);
        checks++; if (gs != e1) begin failures++; $display("FAIL hexdead_str got='%s' want='%s'", gs, e1); end
        checks++; if (len_end != 6 + SP) begin failures++; $display("FAIL hexdead_len got=%0d want=%0d", len_end, 6 + SP); end
        run(32'hFFFF_FFFF, 1'b1, -1);
        checks++; if (gs != e2) begin failures++; $display("FAIL hexff_str got='%s' want='%s'", gs, e2); end
        checks++; if (len_end != 8 + SP) begin failures++; $display("FAIL hexff_len got=%0d want=%0d", len_end, 8 + SP); end
    endtask

    task automatic test_rst_mid();
        string e = {"987654321", SFX};
        int nwe = 0;
        @(negedge clk);
        bus.en = 1'b1; bus.hex = 1'b0; bus.vi = 32'd987654321;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.st !== IDLE || bus.bsy !== 1'b0 || bus.we !== 1'b0 || bus.len !== 4'd0 || bus.ch !== 8'h00)
            begin failures++; $display("FAIL rstmid_outs got=st%0d bsy%b we%b len%0d ch%h want=0", bus.st, bus.bsy, bus.we, bus.len, bus.ch); end
        @(negedge clk); rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.we !== 1'b0 || bus.bsy !== 1'b0) nwe++;
        end
        checks++; if (nwe != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d want=0", nwe); end
        run(32'd987654321, 1'b0, -1);
        checks++; if (gs != e) begin failures++; $display("FAIL rstmid_after got='%s' want='%s'", gs, e); end
    endtask

    task automatic test_en_busy();
        string e = {"12345", SFX};
        run(32'd12345, 1'b0, 5);
        checks++; if (gs != e) begin failures++; $display("FAIL enbusy_str got='%s' want='%s'", gs, e); end
        checks++; if (first_we != 34) begin failures++; $display("FAIL enbusy_lat got=%0d want=34", first_we); end
        checks++; if (len_end != 5 + SP) begin failures++; $display("FAIL enbusy_len got=%0d want=%0d", len_end, 5 + SP); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.bsy !== 1'b0 || bus.we !== 1'b0) begin failures++; $display("FAIL enbusy_idle got=%b%b want=00", bus.bsy, bus.we); end
    endtask

    task automatic test_back_to_back();
        int wes[$];
        int bsy_gap = 1;
        @(negedge clk);
        bus.en = 1'b1; bus.hex = 1'b1; bus.vi = 32'd0;
        @(posedge clk); #1;
        for (int c = 1; c <= 7 + 2 * SP; c++) begin
            @(posedge clk); #1;
            if (bus.we === 1'b1) wes.push_back(c);
            if (bus.bsy !== 1'b1) bsy_gap = 0;
        end
        @(negedge clk); bus.en = 1'b0;
        checks++; if (wes.size() < 2 + 2 * SP) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", wes.size(), 2 + 2 * SP); end
        else begin
            checks++; if (wes[1 + SP] != 5 + 2 * SP) begin failures++; $display("FAIL b2b_second got=%0d want=%0d", wes[1 + SP], 5 + 2 * SP); end
        end
        checks++; if (bsy_gap != 1) begin failures++; $display("FAIL b2b_bsy got=%0d want=1", bsy_gap); end
        repeat (12) @(posedge clk);
    endtask

    initial begin
        bus.en = 1'b0; bus.hex = 1'b0; bus.vi = '0;
        test_reset();
        test_dec_12345();
        test_dec_signed();
        test_zero();
        test_hex();
        test_rst_mid();
        test_en_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
